// File: rtl/execute_stage.sv
// Y86-64 execute stage: ALU, condition codes, Cnd, and the M pipeline register.
// Ports: clk/rst_n; E-register inputs e_*; w_stat; m_stall/m_bubble; e_Cnd/e_valE; m_*; cc_*.
module execute_stage #(
   parameter int W = 64
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [2:0]   e_stat,
   input  logic [3:0]   e_icode,
   input  logic [3:0]   e_ifun,
   input  logic [W-1:0] e_valC,
   input  logic [W-1:0] e_valA,
   input  logic [W-1:0] e_valB,
   input  logic [2:0]   w_stat,
   input  logic         m_stall,
   input  logic         m_bubble,
   output logic         e_Cnd,
   output logic [W-1:0] e_valE,
   output logic [2:0]   m_stat,
   output logic [3:0]   m_icode,
   output logic         m_Cnd,
   output logic [W-1:0] m_valE,
   output logic [W-1:0] m_valA,
   output logic         cc_zf,
   output logic         cc_sf,
   output logic         cc_of
);

   localparam logic [2:0] STAT_AOK = 3'd1;

   localparam logic [3:0] I_NOP    = 4'h1;
   localparam logic [3:0] I_RRMOVQ = 4'h2;
   localparam logic [3:0] I_IRMOVQ = 4'h3;
   localparam logic [3:0] I_RMMOVQ = 4'h4;
   localparam logic [3:0] I_MRMOVQ = 4'h5;
   localparam logic [3:0] I_OPQ    = 4'h6;
   localparam logic [3:0] I_JXX    = 4'h7;
   localparam logic [3:0] I_CALL   = 4'h8;
   localparam logic [3:0] I_RET    = 4'h9;
   localparam logic [3:0] I_PUSHQ  = 4'hA;
   localparam logic [3:0] I_POPQ   = 4'hB;

   localparam logic [3:0] ALU_ADD = 4'h0;
   localparam logic [3:0] ALU_SUB = 4'h1;
   localparam logic [3:0] ALU_AND = 4'h2;
   localparam logic [3:0] ALU_XOR = 4'h3;

   logic [W-1:0] alu_a;
   logic [W-1:0] alu_b;
   logic [3:0]   alu_fun;
   logic [W-1:0] alu_res;
   logic         alu_of;
   logic         set_cc;
   logic         cnd;

   logic         zf_q, zf_d;
   logic         sf_q, sf_d;
   logic         of_q, of_d;

   logic [2:0]   m_stat_q,  m_stat_d;
   logic [3:0]   m_icode_q, m_icode_d;
   logic         m_cnd_q,   m_cnd_d;
   logic [W-1:0] m_vale_q,  m_vale_d;
   logic [W-1:0] m_vala_q,  m_vala_d;

   always_comb begin
      alu_a = '0;
      case (e_icode)
         I_RRMOVQ, I_OPQ:              alu_a = e_valA;
         I_IRMOVQ, I_RMMOVQ, I_MRMOVQ: alu_a = e_valC;
         I_CALL, I_PUSHQ:              alu_a = -W'(8);
         I_RET, I_POPQ:                alu_a = W'(8);
         default:                      alu_a = '0;
      endcase
   end

   always_comb begin
      alu_b = '0;
      case (e_icode)
         I_RMMOVQ, I_MRMOVQ, I_OPQ,
         I_CALL, I_RET, I_PUSHQ, I_POPQ: alu_b = e_valB;
         default:                        alu_b = '0;
      endcase
   end

   assign alu_fun = (e_icode == I_OPQ) ? e_ifun : ALU_ADD;

   // Overflow only exists for ADD/SUB; logic ops and invalid codes clear it.
   always_comb begin
      alu_res = '0;
      alu_of  = 1'b0;
      case (alu_fun)
         ALU_ADD: begin
            alu_res = alu_b + alu_a;
            alu_of  = (alu_a[W-1] == alu_b[W-1]) &&
                      (alu_res[W-1] != alu_a[W-1]);
         end
         ALU_SUB: begin
            alu_res = alu_b - alu_a;
            alu_of  = (alu_a[W-1] != alu_b[W-1]) &&
                      (alu_res[W-1] != alu_b[W-1]);
         end
         ALU_AND: alu_res = alu_b & alu_a;
         ALU_XOR: alu_res = alu_b ^ alu_a;
         default: alu_res = '0;
      endcase
   end

   // A pending exception further down the pipe must not see its CC altered.
   assign set_cc = (e_icode == I_OPQ) && (e_stat == STAT_AOK) &&
                   (m_stat_q == STAT_AOK) && (w_stat == STAT_AOK);

   always_comb begin
      zf_d = zf_q;
      sf_d = sf_q;
      of_d = of_q;
      if (set_cc) begin
         zf_d = (alu_res == '0);
         sf_d = alu_res[W-1];
         of_d = alu_of;
      end
   end

   // Condition uses the flags already in the register, not this cycle's result.
   always_comb begin
      cnd = 1'b0;
      if (e_icode == I_RRMOVQ || e_icode == I_JXX) begin
         case (e_ifun)
            4'd0:    cnd = 1'b1;
            4'd1:    cnd = (sf_q ^ of_q) | zf_q;
            4'd2:    cnd = sf_q ^ of_q;
            4'd3:    cnd = zf_q;
            4'd4:    cnd = ~zf_q;
            4'd5:    cnd = ~(sf_q ^ of_q);
            4'd6:    cnd = ~(sf_q ^ of_q) & ~zf_q;
            default: cnd = 1'b0;
         endcase
      end
   end

   always_comb begin
      m_stat_d  = m_stat_q;
      m_icode_d = m_icode_q;
      m_cnd_d   = m_cnd_q;
      m_vale_d  = m_vale_q;
      m_vala_d  = m_vala_q;
      if (m_bubble) begin
         m_stat_d  = STAT_AOK;
         m_icode_d = I_NOP;
         m_cnd_d   = 1'b0;
         m_vale_d  = '0;
         m_vala_d  = '0;
      end else if (!m_stall) begin
         m_stat_d  = e_stat;
         m_icode_d = e_icode;
         m_cnd_d   = cnd;
         m_vale_d  = alu_res;
         m_vala_d  = e_valA;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         zf_q      <= 1'b1;
         sf_q      <= 1'b0;
         of_q      <= 1'b0;
         m_stat_q  <= STAT_AOK;
         m_icode_q <= I_NOP;
         m_cnd_q   <= 1'b0;
         m_vale_q  <= '0;
         m_vala_q  <= '0;
      end else begin
         zf_q      <= zf_d;
         sf_q      <= sf_d;
         of_q      <= of_d;
         m_stat_q  <= m_stat_d;
         m_icode_q <= m_icode_d;
         m_cnd_q   <= m_cnd_d;
         m_vale_q  <= m_vale_d;
         m_vala_q  <= m_vala_d;
      end
   end

   assign e_valE  = alu_res;
   assign e_Cnd   = cnd;
   assign m_stat  = m_stat_q;
   assign m_icode = m_icode_q;
   assign m_Cnd   = m_cnd_q;
   assign m_valE  = m_vale_q;
   assign m_valA  = m_vala_q;
   assign cc_zf   = zf_q;
   assign cc_sf   = sf_q;
   assign cc_of   = of_q;

endmodule
